fetch_ctrl: RTL

- Program-counter and sequencing stage of the 8-bit CPU.
- Drives the instruction-ROM address that feeds decode, which in turn drives the ALU command.
- Consumes the ALU's branch_bool, using a small loadable branch-target lookup table to redirect the PC.
- Owns run/halt sequencing and the done handshake to the testbench/top level.

---
 rtl/fetch_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Program-counter and sequencing stage of the 8-bit CPU. It drives the
// instruction-ROM address, redirects the PC on taken branches through a small
// loadable branch-target LUT, and owns run/halt sequencing.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   start        level-sampled request to begin/restart execution
//   halt_i       decode: current instruction is the terminal instruction
//   branch_en    decode: current instruction is a conditional branch
//   branch_bool  ALU branch-condition result for the current instruction
//   target_idx   LUT index selected by the current branch instruction
//   lut_we       LUT write enable (accepted in any state)
//   lut_waddr    LUT write index
//   lut_wdata    LUT write data (absolute target PC)
//   pc_o         instruction-ROM address
//   running_o    high while the FSM is in RUN
//   done_o       high while the FSM is in HALT
//   cycle_cnt    RUN cycles of the current/last program (saturating)
//
// Handshake: start is a level request sampled on every rising edge in IDLE or
// HALT; it moves the FSM to RUN from pc 0. done_o rises on the edge after the
// terminal instruction and stays high until the next accepted start. There is
// no backpressure; start is ignored while running.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_i,
  input  logic              branch_en,
  input  logic              branch_bool,
  input  logic [LUT_AW-1:0] target_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc_o,
  output logic              running_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int LUT_N = 2 ** LUT_AW;

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic [PC_W-1:0]   lut_q [LUT_N];
  logic [PC_W-1:0]   lut_d [LUT_N];
  logic              branch_taken;

  // Branch target is read from the registered LUT, so a write landing on the
  // same edge as a taken branch is only seen by later branches.
  assign branch_taken = branch_en && branch_bool;

  always_comb begin
    lut_d = lut_q;
    if (lut_we) begin
      lut_d[lut_waddr] = lut_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Every RUN edge counts, including the one that enters HALT.
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        if (halt_i) begin
          state_d = HALT;
        end else if (branch_taken) begin
          pc_d = lut_q[target_idx];
        end else begin
          pc_d = pc_q + PC_ONE;  // wraps modulo 2**PC_W
        end
      end
      HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
    // Status outputs are registered copies of the next state.
    running_d = (state_d == RUN);
    done_d    = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < LUT_N; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
      lut_q     <= lut_d;
    end
  end

  assign pc_o      = pc_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign cycle_cnt = cnt_q;

endmodule
